// File: rtl/int_pe_col_drain.sv
// -----------------------------------------------------------------------------
// int_pe_col_drain
//
// Bottom-edge result collector for a strip of int_pe columns. Each column's
// 24-bit partial sum leaves the array one cycle later than the column to its
// left. This block delays the earlier columns so a whole array row lines up,
// then buffers the aligned rows in a small registered FIFO that drains
// through a valid/ready stream.
//
// The array cannot be stalled. A row that finds the FIFO full (with no pop
// in the same cycle) is dropped, and the sticky overflow_out flag is raised.
//
// Optional feature (compile-time macro INT_PE_DRAIN_RELU_EN):
//   When it is defined, each column slice is read as signed two's complement
//   and clamped to zero if negative as the row is written into the FIFO.
//   When it is undefined, data passes through bit-exact.
// -----------------------------------------------------------------------------
module int_pe_col_drain #(
   parameter int NUM_COLS      = 4,   // PE columns drained (>= 2)
   parameter int ADD_BIT_WIDTH = 24,  // width of one column partial sum
   parameter int DEPTH         = 4    // FIFO depth in rows (power of 2, >= 2)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              psum_valid_in,
   input  logic [NUM_COLS*ADD_BIT_WIDTH-1:0] bottom_in,
   input  logic                              out_ready,
   input  logic                              overflow_clr_in,
   output logic                              out_valid,
   output logic [NUM_COLS*ADD_BIT_WIDTH-1:0] out_data,
   output logic [$clog2(DEPTH):0]            fifo_count,
   output logic                              overflow_out
);

   localparam int W   = ADD_BIT_WIDTH;
   localparam int RW  = NUM_COLS * ADD_BIT_WIDTH;
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int VSR = NUM_COLS - 1;   // valid pipeline length

   typedef logic [RW-1:0] row_t;

   // ---------------------------------------------------------------------------
   // Deskew
   // Column c is delayed by NUM_COLS-1-c registers, so every column of a row
   // reaches the FIFO input in the same cycle as the last column. The last
   // column needs no delay and is used directly.
   // ---------------------------------------------------------------------------
   row_t         aligned_row;
   logic         aligned_valid;
   logic [VSR-1:0] vld_sr;

   for (genvar c = 0; c < NUM_COLS - 1; c++) begin : g_col
      localparam int L = NUM_COLS - 1 - c;
      logic [W-1:0] sr [L];

      // Per-column delay line; stage 0 samples the column, later stages shift.
      // NOTE: state registers use non-blocking (<=) assignments so that every
      // stage samples its predecessor's pre-edge value; blocking assignments
      // here would collapse the delay line into a single register.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int i = 0; i < L; i++) sr[i] <= '0;
         end else begin
            sr[0] <= bottom_in[c*W +: W];
            for (int i = 1; i < L; i++) sr[i] <= sr[i-1];
         end
      end

      assign aligned_row[c*W +: W] = sr[L-1];
   end

   assign aligned_row[(NUM_COLS-1)*W +: W] = bottom_in[(NUM_COLS-1)*W +: W];

   // Row strobe travels alongside column 0 through a NUM_COLS-1 stage pipe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_sr <= '0;
      else      vld_sr <= (vld_sr << 1) | VSR'(psum_valid_in);
   end

   assign aligned_valid = vld_sr[VSR-1];

   // ---------------------------------------------------------------------------
   // Optional ReLU clamp on the aligned row (combinational, no extra latency)
   // ---------------------------------------------------------------------------
   row_t wr_row;

`ifdef INT_PE_DRAIN_RELU_EN
   // Zero any column slice whose sign bit is set.
   always_comb begin
      wr_row = aligned_row;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (aligned_row[c*W + W - 1]) wr_row[c*W +: W] = '0;
      end
   end
`else
   assign wr_row = aligned_row;
`endif

   // ---------------------------------------------------------------------------
   // Row FIFO: registered storage, no fall-through
   // ---------------------------------------------------------------------------
   row_t            mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;
   logic            empty;
   logic            full;
   logic            pop;
   logic            push;
   logic            drop;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a row
   // when the head is being taken.
   assign pop   = !empty && out_ready;
   assign push  = aligned_valid && (!full || pop);
   assign drop  = aligned_valid && !push;

   // Next occupancy; simultaneous push and pop leave it unchanged.
   always_comb begin
      // NOTE: always_comb outputs get a default before any branch so that no
      // path leaves them unassigned, which would otherwise infer a latch.
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase
   end

   // Pointers and occupancy; the pointers wrap naturally because DEPTH is a
   // power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count_nxt;
      end
   end

   // Row storage write port.
   // NOTE: the storage array is deliberately not reset. Emptiness is tracked
   // by count alone, and out_data is forced to zero while empty, so stale
   // contents are never visible. Leaving the array unreset lets it map onto
   // plain RAM or flops without reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_row;
   end

   // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 overflow_out <= 1'b0;
      else if (drop)            overflow_out <= 1'b1;
      else if (overflow_clr_in) overflow_out <= 1'b0;
   end

   assign out_valid  = !empty;
   assign out_data   = empty ? '0 : mem[rd_ptr];
   assign fifo_count = count;

endmodule

// File: tb/tb_int_pe_col_drain.sv
// -----------------------------------------------------------------------------
// tb_int_pe_col_drain
//
// Self-checking bench for int_pe_col_drain using the default parameters
// (4 columns, 24-bit slices, depth 4). The reference model tracks which rows
// were launched in which cycle, lets each row reach the buffer NUM_COLS-1
// cycles later, and keeps the buffered rows in a queue. Build with
// +define+INT_PE_DRAIN_RELU_EN to check the clamp variant.
// -----------------------------------------------------------------------------
module tb_int_pe_col_drain;

   localparam int NC    = 4;
   localparam int W     = 24;
   localparam int DEPTH = 4;
   localparam int HIST  = 64;

   typedef logic [NC*W-1:0] row_t;

   logic              clk;
   logic              rst;
   logic              psum_valid_in;
   row_t              bottom_in;
   logic              out_ready;
   logic              overflow_clr_in;
   logic              out_valid;
   row_t              out_data;
   logic [$clog2(DEPTH):0] fifo_count;
   logic              overflow_out;

   int vectors;
   int miscompares;

   // Reference model state.
   row_t q[$];            // buffered rows, head at index 0
   bit   m_ovf;
   bit   launched_v [HIST];
   row_t launched_r [HIST];
   int   k;               // cycle index used for launch history

   int_pe_col_drain #(.NUM_COLS(NC), .ADD_BIT_WIDTH(W), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .psum_valid_in   (psum_valid_in),
      .bottom_in       (bottom_in),
      .out_ready       (out_ready),
      .overflow_clr_in (overflow_clr_in),
      .out_valid       (out_valid),
      .out_data        (out_data),
      .fifo_count      (fifo_count),
      .overflow_out    (overflow_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model helpers ----------------
   function automatic row_t relu(input row_t r);
      row_t o;
      o = r;
`ifdef INT_PE_DRAIN_RELU_EN
      for (int c = 0; c < NC; c++) if (r[c*W + W - 1]) o[c*W +: W] = '0;
`endif
      return o;
   endfunction

   function automatic logic m_valid();
      return q.size() != 0;
   endfunction

   function automatic row_t m_data();
      if (q.size() == 0) return '0;
      return q[0];
   endfunction

   function automatic logic [$clog2(DEPTH):0] m_count();
      return ($clog2(DEPTH)+1)'(q.size());
   endfunction

   function automatic row_t rand_row();
      row_t r;
      for (int c = 0; c < NC; c++) r[c*W +: W] = W'($urandom);
      return r;
   endfunction

   function automatic row_t rand_pos_row();
      row_t r;
      r = rand_row();
      for (int c = 0; c < NC; c++) r[c*W + W - 1] = 1'b0;
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      for (int i = 0; i < HIST; i++) launched_v[i] = 1'b0;
   endtask

   // One clock cycle: called just after a falling edge. Drives the inputs,
   // advances the model across the coming rising edge and returns at the
   // next falling edge, when the outputs can be sampled.
   task automatic drive(input logic v, input row_t row, input logic rdy, input logic clr);
      int  slot;
      int  idx;
      bit  pop;
      bit  arr;
      row_t a;
      slot = k % HIST;
      launched_v[slot] = v;
      launched_r[slot] = row;
      psum_valid_in = v;
      for (int c = 0; c < NC; c++) begin
         idx = k - c;
         if (idx >= 0 && launched_v[idx % HIST]) bottom_in[c*W +: W] = launched_r[idx % HIST][c*W +: W];
         else                                    bottom_in[c*W +: W] = W'($urandom);
      end
      out_ready = rdy;
      overflow_clr_in = clr;
      pop = (q.size() != 0) && rdy;
      arr = (k >= NC - 1) && launched_v[(k - NC + 1) % HIST];
      a   = relu(launched_r[(k - NC + 1 + HIST) % HIST]);
      if (pop) void'(q.pop_front());
      if (clr) m_ovf = 1'b0;
      if (arr) begin
         if (q.size() < DEPTH) q.push_back(a);
         else                  m_ovf = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      k++;
   endtask

   task automatic reset_assert();
      #2;
      rst = 1'b0;
      psum_valid_in = 1'b0;
      out_ready = 1'b0;
      overflow_clr_in = 1'b0;
      #1;
   endtask

   task automatic reset_release();
      @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      k += 2;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      // In reset from time zero.
      @(negedge clk);
      vectors++;
      if ({out_valid, fifo_count, overflow_out} !== '0 || out_data !== '0) begin
         miscompares++;
         $display("FAIL reset_initial: valid=%0b cnt=%0d ovf=%0b data=%h, expected all zero",
                  out_valid, fifo_count, overflow_out, out_data);
      end
      #2 rst = 1'b1;
      @(negedge clk);
      // Buffer two rows, then reset asynchronously in mid-cycle.
      drive(1'b1, rand_pos_row(), 1'b0, 1'b0);
      drive(1'b1, rand_pos_row(), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, 1'b0);
      vectors++;
      if (fifo_count !== 3'd2 || out_valid !== 1'b1 || out_data !== m_data()) begin
         miscompares++;
         $display("FAIL reset_prefill: cnt=%0d valid=%0b data=%h, expected cnt=2 valid=1 data=%h",
                  fifo_count, out_valid, out_data, m_data());
      end
      reset_assert();
      vectors++;
      if ({out_valid, fifo_count, overflow_out} !== '0 || out_data !== '0) begin
         miscompares++;
         $display("FAIL reset_async: valid=%0b cnt=%0d ovf=%0b data=%h, expected all zero",
                  out_valid, fifo_count, overflow_out, out_data);
      end
      reset_release();
   endtask

   task automatic test_single_row();
      row_t r;
      logic exp_v;
      for (int c = 0; c < NC; c++) r[c*W +: W] = W'(24'h000100 + c);
      for (int j = 1; j <= 7; j++) begin
         drive(j == 1, (j == 1) ? r : row_t'('0), 1'b1, 1'b0);
         exp_v = (j == NC);
         vectors++;
         if (out_valid !== exp_v || out_valid !== m_valid()) begin
            miscompares++;
            $display("FAIL single_valid cyc=%0d: valid=%0b, expected %0b", j, out_valid, exp_v);
         end
         if (j == NC) begin
            vectors++;
            if (out_data !== r || out_data !== m_data()) begin
               miscompares++;
               $display("FAIL single_data: got %h, expected %h", out_data, r);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      row_t r [5];
      for (int i = 0; i < 5; i++) r[i] = rand_pos_row();
      for (int i = 0; i < 5; i++) drive(1'b1, r[i], 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, 1'b0);
      vectors++;
      if (fifo_count !== 3'd4 || overflow_out !== 1'b1 || out_valid !== 1'b1 || out_data !== r[0]) begin
         miscompares++;
         $display("FAIL bp_full: cnt=%0d ovf=%0b valid=%0b data=%h, expected cnt=4 ovf=1 valid=1 data=%h",
                  fifo_count, overflow_out, out_valid, out_data, r[0]);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (out_valid !== 1'b1 || out_data !== r[i] || out_data !== m_data()) begin
            miscompares++;
            $display("FAIL bp_drain%0d: valid=%0b data=%h, expected valid=1 data=%h",
                     i, out_valid, out_data, r[i]);
         end
         drive(1'b0, '0, 1'b1, 1'b0);
      end
      vectors++;
      if (out_valid !== 1'b0 || fifo_count !== 3'd0 || overflow_out !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_empty: valid=%0b cnt=%0d ovf=%0b, expected valid=0 cnt=0 ovf=1",
                  out_valid, fifo_count, overflow_out);
      end
      drive(1'b0, '0, 1'b0, 1'b1);
      vectors++;
      if (overflow_out !== 1'b0 || overflow_out !== m_ovf) begin
         miscompares++;
         $display("FAIL bp_clear: ovf=%0b, expected 0", overflow_out);
      end
      overflow_clr_in = 1'b0;
   endtask

   task automatic test_full_pop();
      row_t r [5];
      for (int i = 0; i < 5; i++) r[i] = rand_pos_row();
      for (int i = 0; i < 5; i++) drive(1'b1, r[i], 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      vectors++;
      if (fifo_count !== 3'd4 || overflow_out !== 1'b0) begin
         miscompares++;
         $display("FAIL fp_fill: cnt=%0d ovf=%0b, expected cnt=4 ovf=0", fifo_count, overflow_out);
      end
      // Fifth row reaches the buffer in the same cycle the head is popped.
      drive(1'b0, '0, 1'b1, 1'b0);
      vectors++;
      if (fifo_count !== 3'd4 || overflow_out !== 1'b0 || out_data !== r[1]) begin
         miscompares++;
         $display("FAIL fp_swap: cnt=%0d ovf=%0b data=%h, expected cnt=4 ovf=0 data=%h",
                  fifo_count, overflow_out, out_data, r[1]);
      end
      for (int i = 1; i < 5; i++) begin
         vectors++;
         if (out_valid !== 1'b1 || out_data !== r[i] || out_data !== m_data()) begin
            miscompares++;
            $display("FAIL fp_order%0d: valid=%0b data=%h, expected %h", i, out_valid, out_data, r[i]);
         end
         drive(1'b0, '0, 1'b1, 1'b0);
      end
      vectors++;
      if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
         miscompares++;
         $display("FAIL fp_empty: valid=%0b cnt=%0d, expected 0 0", out_valid, fifo_count);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, rand_pos_row(), 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0);
      drive(1'b1, rand_pos_row(), 1'b0, 1'b0);
      drive(1'b1, rand_pos_row(), 1'b0, 1'b0);
      vectors++;
      if (fifo_count !== 3'd1) begin
         miscompares++;
         $display("FAIL rm_pre: cnt=%0d, expected 1", fifo_count);
      end
      reset_assert();
      reset_release();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         vectors++;
         if (out_valid !== 1'b0 || fifo_count !== 3'd0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL rm_quiet%0d: valid=%0b cnt=%0d data=%h, expected 0 0 0",
                     i, out_valid, fifo_count, out_data);
         end
      end
   endtask

   task automatic test_relu();
      row_t r;
      row_t exp_r;
      r[0*W +: W] = 24'h000011;
      r[1*W +: W] = 24'hFFFFF0;
      r[2*W +: W] = 24'h7FFFFF;
      r[3*W +: W] = 24'h000003;
      exp_r = r;
`ifdef INT_PE_DRAIN_RELU_EN
      exp_r[1*W +: W] = 24'h000000;
`endif
      drive(1'b1, r, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_r || out_data !== m_data()) begin
         miscompares++;
         $display("FAIL relu: valid=%0b data=%h, expected valid=1 data=%h", out_valid, out_data, exp_r);
      end
      drive(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic v;
      logic rdy;
      logic clr;
      int   bad;
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         v   = ($urandom_range(0, 9) < 6);
         rdy = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
         clr = ($urandom_range(0, 19) == 0);
         drive(v, rand_row(), rdy, clr);
         vectors++;
         if (out_valid !== m_valid() || fifo_count !== m_count() ||
             overflow_out !== m_ovf || out_data !== m_data()) begin
            miscompares++;
            if (bad < 10)
               $display("FAIL random cyc=%0d: valid=%0b cnt=%0d ovf=%0b data=%h, expected valid=%0b cnt=%0d ovf=%0b data=%h",
                        i, out_valid, fifo_count, overflow_out, out_data,
                        m_valid(), m_count(), m_ovf, m_data());
            bad++;
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      k = 0;
      rst = 1'b0;
      psum_valid_in = 1'b0;
      bottom_in = '0;
      out_ready = 1'b0;
      overflow_clr_in = 1'b0;
      model_reset();

      test_reset();
      test_single_row();
      test_backpressure();
      test_full_pop();
      test_reset_mid();
      test_relu();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
